lt24_pixel_writer: RTL and testbench

- Bus-side responder for the pixel write handshake used by the display path (xAddr/yAddr/pixelData/pixelWrite/pixelReady).
- Accepts one pixel per handshake and drives the LT24 8080-style parallel write bus.
- Emits column-address (0x2A), page-address (0x2B) and memory-write (0x2C) command sequences only when an incoming pixel breaks the controller's auto-increment raster. In-sequence pixels cost a single bus word.
- Sits between the maze renderer and the LT24 pins, replacing the generic pixel path when no command interface is needed.

---
 rtl/lt24_pixel_writer.sv | 140 ++++++++++++++
 tb/tb_lt24_pixel_writer.sv | 164 ++++++++++++++++
 2 files changed

// File: rtl/lt24_pixel_writer.sv
// lt24_pixel_writer: pixel handshake to LT24 8080 write bus, re-addressing only on raster breaks.
// Define LT24_PIXEL_WRITER_FORCE_ADDR_EN to send the full address sequence for every pixel.
module lt24_pixel_writer #(
    parameter int WIDTH          = 240,
    parameter int HEIGHT         = 320,
    parameter int WR_LOW_CYCLES  = 2,
    parameter int WR_HIGH_CYCLES = 1
) (
    input  logic        clock,
    input  logic        globalReset,
    input  logic [7:0]  xAddr,
    input  logic [8:0]  yAddr,
    input  logic [15:0] pixelData,
    input  logic        pixelWrite,
    output logic        pixelReady,
    output logic        LT24_CSn,
    output logic        LT24_RS,
    output logic        LT24_WRn,
    output logic [15:0] LT24_D
);
    localparam logic [1:0]  IDLE = 2'd0, WRLO = 2'd1, WRHI = 2'd2;
    localparam logic [15:0] END_C = 16'(WIDTH - 1);
    localparam logic [15:0] END_R = 16'(HEIGHT - 1);
    logic [1:0]  state;
    logic [3:0]  idx, start_idx;
    logic [7:0]  cnt;
    logic [7:0]  x_q, win_x0, nxt_x, wx;
    logic [8:0]  y_q, win_y0, nxt_y, wy;
    logic [15:0] pix_q;
    logic        stream_valid, in_range, hit, wrap_x, wrap_y, lo_done, hi_done, last;
    logic [16:0] first_w, next_w;

    // Returns {rs, data}; index 11 is the pixel word, so a short sequence simply starts there.
    function automatic logic [16:0] word_of(input logic [3:0] i, input logic [7:0] x,
                                            input logic [8:0] y, input logic [15:0] p);
        case (i)
            4'd0:    word_of = {1'b0, 16'h002A};
            4'd1:    word_of = {1'b1, 16'h0000};
            4'd2:    word_of = {1'b1, 8'h00, x};
            4'd3:    word_of = {1'b1, 8'h00, END_C[15:8]};
            4'd4:    word_of = {1'b1, 8'h00, END_C[7:0]};
            4'd5:    word_of = {1'b0, 16'h002B};
            4'd6:    word_of = {1'b1, 15'h0000, y[8]};
            4'd7:    word_of = {1'b1, 8'h00, y[7:0]};
            4'd8:    word_of = {1'b1, 8'h00, END_R[15:8]};
            4'd9:    word_of = {1'b1, 8'h00, END_R[7:0]};
            4'd10:   word_of = {1'b0, 16'h002C};
            default: word_of = {1'b1, p};
        endcase
    endfunction

    always_comb begin
        in_range  = int'(xAddr) < WIDTH && int'(yAddr) < HEIGHT;
`ifdef LT24_PIXEL_WRITER_FORCE_ADDR_EN
        hit       = 1'b0;
`else
        hit       = stream_valid && xAddr == nxt_x && yAddr == nxt_y;
`endif
        start_idx = hit ? 4'd11 : 4'd0;
        wx        = hit ? win_x0 : xAddr;
        wy        = hit ? win_y0 : yAddr;
        wrap_x    = int'(xAddr) >= WIDTH - 1;
        wrap_y    = int'(yAddr) >= HEIGHT - 1;
        first_w   = word_of(start_idx, xAddr, yAddr, pixelData);
        next_w    = word_of(idx + 4'd1, x_q, y_q, pix_q);
        lo_done   = cnt == 8'(WR_LOW_CYCLES - 1);
        hi_done   = cnt == 8'(WR_HIGH_CYCLES - 1);
        last      = idx == 4'd11;
    end

    always_ff @(posedge clock or negedge globalReset) begin
        if (!globalReset) begin
            state        <= IDLE;
            idx          <= '0;
            cnt          <= '0;
            x_q          <= '0;
            y_q          <= '0;
            pix_q        <= '0;
            win_x0       <= '0;
            win_y0       <= '0;
            nxt_x        <= '0;
            nxt_y        <= '0;
            stream_valid <= 1'b0;
            pixelReady   <= 1'b0;
            LT24_CSn     <= 1'b1;
            LT24_WRn     <= 1'b1;
            LT24_RS      <= 1'b1;
            LT24_D       <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (!pixelReady) begin
                        pixelReady <= 1'b1;
                    end else if (pixelWrite) begin
                        pixelReady <= 1'b0;
                        if (in_range) begin
                            x_q                <= xAddr;
                            y_q                <= yAddr;
                            pix_q              <= pixelData;
                            win_x0             <= wx;
                            win_y0             <= wy;
                            stream_valid       <= 1'b1;
                            nxt_x              <= wrap_x ? wx : xAddr + 8'd1;
                            nxt_y              <= !wrap_x ? yAddr : wrap_y ? wy : yAddr + 9'd1;
                            idx                <= start_idx;
                            cnt                <= '0;
                            state              <= WRLO;
                            LT24_CSn           <= 1'b0;
                            LT24_WRn           <= 1'b0;
                            {LT24_RS, LT24_D}  <= first_w;
                        end else begin
                            stream_valid <= 1'b0;
                        end
                    end
                end
                WRLO: begin
                    cnt <= lo_done ? 8'd0 : cnt + 8'd1;
                    if (lo_done) begin
                        LT24_WRn <= 1'b1;
                        state    <= WRHI;
                    end
                end
                WRHI: begin
                    cnt <= hi_done ? 8'd0 : cnt + 8'd1;
                    if (hi_done && last) begin
                        state      <= IDLE;
                        LT24_CSn   <= 1'b1;
                        pixelReady <= 1'b1;
                    end else if (hi_done) begin
                        idx               <= idx + 4'd1;
                        state             <= WRLO;
                        LT24_WRn          <= 1'b0;
                        {LT24_RS, LT24_D} <= next_w;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_lt24_pixel_writer.sv
// tb_lt24_pixel_writer: directed pixels, expected bus words queued at drive time and checked at each WRn rise.
module tb_lt24_pixel_writer;
    logic        clock = 1'b0;
    logic        globalReset = 1'b0;
    logic [7:0]  xAddr = '0;
    logic [8:0]  yAddr = '0;
    logic [15:0] pixelData = '0;
    logic        pixelWrite = 1'b0;
    logic        pixelReady, LT24_CSn, LT24_RS, LT24_WRn;
    logic [15:0] LT24_D;
    int          checks = 0;
    int          failures = 0;
    int          words_seen = 0;
    logic [16:0] q[$];
`ifdef LT24_PIXEL_WRITER_FORCE_ADDR_EN
    localparam bit FORCE = 1'b1;
`else
    localparam bit FORCE = 1'b0;
`endif

    always #10 clock = ~clock;

    lt24_pixel_writer dut (
        .clock(clock), .globalReset(globalReset), .xAddr(xAddr), .yAddr(yAddr),
        .pixelData(pixelData), .pixelWrite(pixelWrite), .pixelReady(pixelReady),
        .LT24_CSn(LT24_CSn), .LT24_RS(LT24_RS), .LT24_WRn(LT24_WRn), .LT24_D(LT24_D)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Bus monitor: the panel latches on the WRn rising edge.
    logic prev_wrn = 1'b1;
    int   low_cnt = 0;
    always @(negedge clock) begin
        logic [16:0] e;
        if (!globalReset) begin
            low_cnt = 0;
        end else if (LT24_WRn === 1'b0) begin
            low_cnt++;
        end else if (prev_wrn === 1'b0) begin
            words_seen++;
            chk("wr_low_cycles", low_cnt, 2);
            chk("csn_during_write", {31'd0, LT24_CSn}, 0);
            if (q.size() == 0) begin
                chk("word_expected", q.size(), 1);
            end else begin
                e = q.pop_front();
                chk("bus_word", {15'd0, LT24_RS, LT24_D}, {15'd0, e});
            end
            low_cnt = 0;
        end
        prev_wrn = LT24_WRn;
    end

    task automatic push_full(input logic [7:0] x, input logic [8:0] y, input logic [15:0] p);
        q.push_back({1'b0, 16'h002A});
        q.push_back({1'b1, 16'h0000});
        q.push_back({1'b1, 8'h00, x});
        q.push_back({1'b1, 16'h0000});
        q.push_back({1'b1, 16'h00EF});
        q.push_back({1'b0, 16'h002B});
        q.push_back({1'b1, 15'h0000, y[8]});
        q.push_back({1'b1, 8'h00, y[7:0]});
        q.push_back({1'b1, 16'h0001});
        q.push_back({1'b1, 16'h003F});
        q.push_back({1'b0, 16'h002C});
        q.push_back({1'b1, p});
    endtask

    // mode: 0 = discarded, 1 = short, 2 = full
    task automatic send(input logic [7:0] x, input logic [8:0] y, input logic [15:0] p,
                        input int mode_in, input bit wait_done);
        int n = 0;
        int k = 0;
        int mode = (mode_in == 1 && FORCE) ? 2 : mode_in;
        while (pixelReady !== 1'b1 && n < 200) begin
            @(negedge clock);
            n++;
        end
        chk("ready_before_send", {31'd0, pixelReady}, 1);
        if (mode == 2) push_full(x, y, p);
        if (mode == 1) q.push_back({1'b1, p});
        xAddr = x;
        yAddr = y;
        pixelData = p;
        pixelWrite = 1'b1;
        @(negedge clock);
        pixelWrite = 1'b0;
        if (wait_done) begin
            while (pixelReady !== 1'b1 && k < 200) begin
                k++;
                if (mode == 0) begin
                    chk("discard_csn", {31'd0, LT24_CSn}, 1);
                    chk("discard_wrn", {31'd0, LT24_WRn}, 1);
                end
                @(negedge clock);
            end
            chk("busy_cycles", k, mode == 2 ? 36 : mode == 1 ? 3 : 1);
            chk("queue_drained", q.size(), 0);
        end
    endtask

    initial begin
        int n;
        int base;
        #25;
        chk("rst_ready", {31'd0, pixelReady}, 0);
        chk("rst_csn", {31'd0, LT24_CSn}, 1);
        chk("rst_wrn", {31'd0, LT24_WRn}, 1);
        chk("rst_rs", {31'd0, LT24_RS}, 1);
        chk("rst_d", {16'd0, LT24_D}, 0);
        @(negedge clock);
        globalReset = 1'b1;
        @(negedge clock);
        chk("ready_after_release", {31'd0, pixelReady}, 1);
        send(8'd0, 9'd0, 16'hF800, 2, 1'b1);
        send(8'd1, 9'd0, 16'h07E0, 1, 1'b1);
        send(8'd10, 9'd5, 16'h001F, 2, 1'b1);
        for (int x = 11; x <= 239; x++) send(8'(x), 9'd5, 16'(x), 1, 1'b1);
        send(8'd10, 9'd6, 16'hAAAA, 1, 1'b1);
        send(8'd0, 9'd6, 16'hBBBB, 2, 1'b1);
        send(8'd240, 9'd0, 16'hCCCC, 0, 1'b1);
        send(8'd11, 9'd6, 16'hDDDD, 2, 1'b1);
        send(8'd5, 9'd320, 16'hEEEE, 0, 1'b1);
        // Abort a full sequence while word 5 is on the bus.
        base = words_seen;
        send(8'd20, 9'd6, 16'h1234, 2, 1'b0);
        n = 0;
        while (words_seen < base + 5 && n < 500) begin
            @(negedge clock);
            n++;
        end
        chk("words_before_abort", words_seen - base, 5);
        @(posedge clock);
        #3 globalReset = 1'b0;
        #1;
        chk("abort_wrn", {31'd0, LT24_WRn}, 1);
        chk("abort_csn", {31'd0, LT24_CSn}, 1);
        chk("abort_ready", {31'd0, pixelReady}, 0);
        chk("abort_rs", {31'd0, LT24_RS}, 1);
        chk("abort_d", {16'd0, LT24_D}, 0);
        q.delete();
        @(negedge clock);
        @(negedge clock);
        globalReset = 1'b1;
        send(8'd12, 9'd6, 16'h5555, 2, 1'b1);
        send(8'd13, 9'd6, 16'h6666, 1, 1'b1);
        chk("final_queue_empty", q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog timeout checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog");
    end
endmodule
